// File: rtl/ibex_fetch_req_sched_if.sv
// Instruction-memory bus bundle between the fetch request scheduler and the
// memory side. Signal names carry the scheduler's point of view (_o driven
// by the scheduler, _i driven by memory).
//   instr_req_o    : request valid, held until granted
//   instr_addr_o   : word-aligned request address
//   instr_gnt_i    : request accepted this cycle
//   instr_rvalid_i : in-order response valid
//   instr_rdata_i  : response data
//   instr_err_i    : response error
interface ibex_fetch_req_sched_if;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic        instr_err_i;

    modport master (
        output instr_req_o, instr_addr_o,
        input  instr_gnt_i, instr_rvalid_i, instr_rdata_i, instr_err_i
    );

    modport slave (
        input  instr_req_o, instr_addr_o,
        output instr_gnt_i, instr_rvalid_i, instr_rdata_i, instr_err_i
    );
endinterface

// File: rtl/ibex_fetch_req_sched.sv
// Fetch request scheduler for the IF stage.
// Issues sequential word fetches, holds a request stable until granted,
// tracks up to NUM_REQS outstanding responses in order, marks in-flight
// responses for discard on a branch and throttles issue so the fetch FIFO
// can never overflow.
// Ports:
//   clk_i, rst_i        : clock, synchronous active-high reset
//   req_i               : fetch enable
//   branch_i            : single-cycle redirect pulse
//   branch_addr_i       : redirect target (halfword aligned)
//   fifo_busy_i         : FIFO upper-entry occupancy
//   fifo_clear_o/addr_o : FIFO clear and realign address (combinational)
//   fifo_valid_o/rdata_o/err_o : FIFO push of live responses
//   instr_bus           : instruction-memory bus (master side)
//   busy_o              : request held or responses outstanding
module ibex_fetch_req_sched #(
    parameter int unsigned NUM_REQS = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_i,
    input  logic                    branch_i,
    input  logic [31:0]             branch_addr_i,
    input  logic [NUM_REQS-1:0]     fifo_busy_i,
    output logic                    fifo_clear_o,
    output logic                    fifo_valid_o,
    output logic [31:0]             fifo_addr_o,
    output logic [31:0]             fifo_rdata_o,
    output logic                    fifo_err_o,
    ibex_fetch_req_sched_if.master  instr_bus,
    output logic                    busy_o
);
    localparam int unsigned CNT_W = $clog2(NUM_REQS + 1);

    typedef enum logic {IDLE, WAIT_GNT} state_e;

    state_e                 state_q, state_d;
    logic [31:0]            fetch_addr_q, fetch_addr_d;
    logic [31:0]            held_addr_q, held_addr_d;
    logic                   held_discard_q, held_discard_d;
    logic [NUM_REQS-1:0]    valid_q, valid_d;
    logic [NUM_REQS-1:0]    disc_q, disc_d;

    logic [CNT_W:0]         busy_cnt, outstanding_cnt, slots_used;
    logic                   permitted;
    logic [31:0]            branch_word;
    logic [31:0]            issue_addr;
    logic                   req_out;
    logic [31:0]            addr_out;
    logic                   push, pop, push_disc;
    logic [NUM_REQS-1:0]    v_shift, d_shift, free_here;

    assign branch_word = {branch_addr_i[31:2], 2'b00};
    assign issue_addr  = branch_i ? branch_word : fetch_addr_q;

    // The FIFO is being cleared on a branch, so its occupancy does not count.
    always_comb begin
        busy_cnt        = '0;
        outstanding_cnt = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (fifo_busy_i[i] && !branch_i)
                busy_cnt = busy_cnt + (CNT_W+1)'(1);
            if (valid_q[i])
                outstanding_cnt = outstanding_cnt + (CNT_W+1)'(1);
        end
    end

    assign slots_used = busy_cnt + outstanding_cnt;
    assign permitted  = req_i && (slots_used < (CNT_W+1)'(NUM_REQS));

    // FSM: state register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (permitted && !instr_bus.instr_gnt_i) state_d = WAIT_GNT;
            WAIT_GNT: if (instr_bus.instr_gnt_i)               state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // FSM: outputs. A held request ignores req_i and throttling so the bus
    // sees a stable request until it is granted.
    always_comb begin
        req_out  = permitted;
        addr_out = issue_addr;
        if (state_q == WAIT_GNT) begin
            req_out  = 1'b1;
            addr_out = held_addr_q;
        end
    end

    assign instr_bus.instr_req_o  = req_out;
    assign instr_bus.instr_addr_o = addr_out;

    assign push = req_out && instr_bus.instr_gnt_i;
    assign pop  = instr_bus.instr_rvalid_i && valid_q[0];
    // Only a held request can be stale; an IDLE issue on a branch already
    // targets the new address.
    assign push_disc = (state_q == WAIT_GNT) && (held_discard_q || branch_i);

    always_comb begin
        fetch_addr_d   = fetch_addr_q;
        held_addr_d    = held_addr_q;
        held_discard_d = held_discard_q;
        if (state_q == IDLE) begin
            held_discard_d = 1'b0;
            if (permitted && instr_bus.instr_gnt_i)
                fetch_addr_d = issue_addr + 32'd4;
            else if (branch_i)
                fetch_addr_d = branch_word;
            if (permitted && !instr_bus.instr_gnt_i)
                held_addr_d = issue_addr;
        end else begin
            // A branch seen while held already set fetch_addr_q to its target.
            if (branch_i)
                fetch_addr_d = branch_word;
            else if (instr_bus.instr_gnt_i && !held_discard_q)
                fetch_addr_d = held_addr_q + 32'd4;
            held_discard_d = instr_bus.instr_gnt_i ? 1'b0 : (held_discard_q || branch_i);
        end
    end

    // Outstanding queue: shift on pop, apply branch discard to the survivors,
    // then place a push in the first free slot.
    for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_queue
        if (gi < NUM_REQS - 1) begin : g_mid
            assign v_shift[gi] = pop ? valid_q[gi+1] : valid_q[gi];
            assign d_shift[gi] = pop ? disc_q[gi+1]  : disc_q[gi];
        end else begin : g_last
            assign v_shift[gi] = pop ? 1'b0 : valid_q[gi];
            assign d_shift[gi] = pop ? 1'b0 : disc_q[gi];
        end
        if (gi == 0) begin : g_first
            assign free_here[gi] = !v_shift[gi];
        end else begin : g_rest
            assign free_here[gi] = !v_shift[gi] && v_shift[gi-1];
        end
        assign valid_d[gi] = v_shift[gi] || (push && free_here[gi]);
        assign disc_d[gi]  = (push && free_here[gi]) ? push_disc
                                                     : ((d_shift[gi] || branch_i) && v_shift[gi]);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_addr_q   <= '0;
            held_addr_q    <= '0;
            held_discard_q <= 1'b0;
            valid_q        <= '0;
            disc_q         <= '0;
        end else begin
            fetch_addr_q   <= fetch_addr_d;
            held_addr_q    <= held_addr_d;
            held_discard_q <= held_discard_d;
            valid_q        <= valid_d;
            disc_q         <= disc_d;
        end
    end

    assign fifo_clear_o = branch_i;
    assign fifo_addr_o  = branch_addr_i;
    assign fifo_valid_o = instr_bus.instr_rvalid_i && valid_q[0] && !disc_q[0] && !branch_i;
    assign fifo_rdata_o = instr_bus.instr_rdata_i;
    assign fifo_err_o   = instr_bus.instr_err_i;
    assign busy_o       = (state_q == WAIT_GNT) || (outstanding_cnt != '0);

    a_rvalid_has_entry: assert property (@(posedge clk_i) disable iff (rst_i)
        instr_bus.instr_rvalid_i |-> valid_q[0]);
    a_gnt_needs_req: assert property (@(posedge clk_i) disable iff (rst_i)
        instr_bus.instr_gnt_i |-> req_out);
    a_cnt_bound: assert property (@(posedge clk_i) disable iff (rst_i)
        outstanding_cnt <= (CNT_W+1)'(NUM_REQS));
    a_addr_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (req_out && !instr_bus.instr_gnt_i) |=> $stable(addr_out));
endmodule

// File: tb/tb_ibex_fetch_req_sched.sv
module tb_ibex_fetch_req_sched;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i, branch_i;
    logic [31:0] branch_addr_i;
    logic [1:0]  fifo_busy_i;
    logic        fifo_clear_o, fifo_valid_o, fifo_err_o, busy_o;
    logic [31:0] fifo_addr_o, fifo_rdata_o;

    ibex_fetch_req_sched_if bus ();

    ibex_fetch_req_sched #(.NUM_REQS(2)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req_i         (req_i),
        .branch_i      (branch_i),
        .branch_addr_i (branch_addr_i),
        .fifo_busy_i   (fifo_busy_i),
        .fifo_clear_o  (fifo_clear_o),
        .fifo_valid_o  (fifo_valid_o),
        .fifo_addr_o   (fifo_addr_o),
        .fifo_rdata_o  (fifo_rdata_o),
        .fifo_err_o    (fifo_err_o),
        .instr_bus     (bus.master),
        .busy_o        (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    // Reference model: pending (ungranted) request, next sequential address
    // and the in-order list of outstanding responses' discard flags.
    bit          m_wait;
    bit          m_hdisc;
    logic [31:0] m_held;
    logic [31:0] m_next;
    bit          q[$];

    // Last observed DUT outputs, for the literal expectations.
    logic        o_req, o_clear, o_fvalid, o_ferr, o_busy;
    logic [31:0] o_addr, o_faddr, o_frdata;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1; req_i = 1'b0; branch_i = 1'b0; branch_addr_i = '0;
        fifo_busy_i = '0; bus.instr_gnt_i = 1'b0; bus.instr_rvalid_i = 1'b0;
        bus.instr_rdata_i = '0; bus.instr_err_i = 1'b0;
        @(posedge clk_i);
        m_wait = 0; m_hdisc = 0; m_held = '0; m_next = '0; q.delete();
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_req", bus.instr_req_o, 0);
        $display("reset: busy=%0b req=%0b", busy_o, bus.instr_req_o);
    endtask

    task automatic cycle(input bit req, input bit br, input logic [31:0] ba, input logic [1:0] fb,
                         input bit gnt_en, input bit rv_en, input logic [31:0] rd, input bit er);
        logic [31:0] tgt, al;
        int          occ;
        bit          e_req, e_fv, rv, g;
        logic [31:0] e_addr;
        @(negedge clk_i);
        rv = rv_en && (q.size() != 0);
        req_i = req; branch_i = br; branch_addr_i = ba; fifo_busy_i = fb;
        bus.instr_rvalid_i = rv; bus.instr_rdata_i = rd; bus.instr_err_i = er;
        bus.instr_gnt_i = 1'b0;
        #1;
        g = gnt_en && (bus.instr_req_o === 1'b1);
        bus.instr_gnt_i = g;
        #1;
        al  = {ba[31:2], 2'b00};
        tgt = br ? al : m_next;
        occ = q.size() + (br ? 0 : $countones(fb));
        if (m_wait) begin
            e_req = 1; e_addr = m_held;
        end else begin
            e_req = req && (occ < 2); e_addr = tgt;
        end
        e_fv = rv && (q.size() != 0) && !q[0] && !br;

        o_req = bus.instr_req_o; o_addr = bus.instr_addr_o; o_clear = fifo_clear_o;
        o_faddr = fifo_addr_o; o_fvalid = fifo_valid_o; o_frdata = fifo_rdata_o;
        o_ferr = fifo_err_o; o_busy = busy_o;

        chk("req", o_req, e_req);
        if (e_req) chk("addr", o_addr, e_addr);
        chk("clear", o_clear, br);
        chk("fifo_addr", o_faddr, ba);
        chk("fifo_valid", o_fvalid, e_fv);
        if (e_fv) begin
            chk("fifo_rdata", o_frdata, rd);
            chk("fifo_err", o_ferr, er);
        end
        chk("busy", o_busy, m_wait || (q.size() != 0));
        $display("cyc req=%0b addr=%08h gnt=%0b br=%0b rv=%0b fv=%0b out=%0d",
                 o_req, o_addr, g, br, rv, o_fvalid, q.size());

        @(posedge clk_i);
        if (rv) void'(q.pop_front());
        if (br) foreach (q[i]) q[i] = 1;
        if (e_req && g) begin
            q.push_back(m_wait ? (m_hdisc || br) : 1'b0);
            if (m_wait) m_next = br ? al : (m_hdisc ? m_next : m_held + 32'd4);
            else        m_next = tgt + 32'd4;
            m_wait = 0; m_hdisc = 0;
        end else if (m_wait) begin
            if (br) begin m_next = al; m_hdisc = 1; end
        end else if (e_req) begin
            m_wait = 1; m_held = tgt; m_hdisc = 0;
        end else if (br) begin
            m_next = al;
        end
    endtask

    initial begin
        rst_i = 1'b1; req_i = 0; branch_i = 0; branch_addr_i = '0; fifo_busy_i = '0;
        bus.instr_gnt_i = 0; bus.instr_rvalid_i = 0; bus.instr_rdata_i = '0; bus.instr_err_i = 0;

        // Sequential fetch from a branch target
        do_reset();
        cycle(1, 1, 32'h100, 2'b00, 1, 0, 32'h0, 0);
        chk("t1_addr0", o_addr, 32'h100);
        cycle(1, 0, 32'h0, 2'b00, 1, 1, 32'h1111_0000, 0);
        chk("t1_addr1", o_addr, 32'h104);
        chk("t1_push", o_fvalid, 1);
        cycle(1, 0, 32'h0, 2'b00, 1, 1, 32'h1111_0004, 0);
        chk("t1_addr2", o_addr, 32'h108);

        // Unaligned branch target
        cycle(1, 1, 32'h202, 2'b00, 1, 1, 32'h2222_0000, 0);
        chk("t2_addr", o_addr, 32'h200);
        chk("t2_clear", o_clear, 1);
        chk("t2_faddr", o_faddr, 32'h202);
        chk("t2_nopush", o_fvalid, 0);

        // Branch with two responses in flight
        do_reset();
        cycle(1, 1, 32'h1000, 2'b00, 1, 0, 32'h0, 0);
        cycle(1, 0, 32'h0, 2'b00, 1, 0, 32'h0, 0);
        cycle(1, 1, 32'h400, 2'b00, 1, 0, 32'h0, 0);
        chk("t3_full", o_req, 0);
        cycle(0, 0, 32'h0, 2'b00, 0, 1, 32'h3333_0000, 0);
        chk("t3_drop0", o_fvalid, 0);
        cycle(0, 0, 32'h0, 2'b00, 0, 1, 32'h3333_0004, 0);
        chk("t3_drop1", o_fvalid, 0);
        cycle(1, 0, 32'h0, 2'b00, 0, 0, 32'h0, 0);
        chk("t3_next", o_addr, 32'h400);

        // Held request across a branch
        do_reset();
        cycle(1, 1, 32'h300, 2'b00, 0, 0, 32'h0, 0);
        chk("t4_h0", o_addr, 32'h300);
        cycle(0, 1, 32'h500, 2'b00, 0, 0, 32'h0, 0);
        chk("t4_h1", o_addr, 32'h300);
        chk("t4_hreq", o_req, 1);
        cycle(0, 0, 32'h0, 2'b00, 0, 0, 32'h0, 0);
        chk("t4_h2", o_addr, 32'h300);
        cycle(0, 0, 32'h0, 2'b00, 1, 0, 32'h0, 0);
        chk("t4_h3", o_addr, 32'h300);
        cycle(1, 0, 32'h0, 2'b00, 0, 1, 32'h4444_0000, 0);
        chk("t4_drop", o_fvalid, 0);
        chk("t4_next", o_addr, 32'h500);

        // Throttling against FIFO occupancy
        do_reset();
        cycle(1, 1, 32'h600, 2'b00, 1, 0, 32'h0, 0);
        cycle(1, 0, 32'h0, 2'b01, 1, 0, 32'h0, 0);
        chk("t5_throttle", o_req, 0);
        cycle(1, 0, 32'h0, 2'b00, 1, 0, 32'h0, 0);
        chk("t5_resume", o_req, 1);
        chk("t5_addr", o_addr, 32'h604);

        // Address wrap and error response
        do_reset();
        cycle(1, 1, 32'hFFFF_FFFC, 2'b00, 1, 0, 32'h0, 0);
        chk("t6_top", o_addr, 32'hFFFF_FFFC);
        cycle(1, 0, 32'h0, 2'b00, 1, 1, 32'hDEAD_BEEF, 1);
        chk("t6_wrap", o_addr, 32'h0);
        chk("t6_err", o_ferr, 1);
        chk("t6_rdata", o_frdata, 32'hDEAD_BEEF);
        cycle(1, 0, 32'h0, 2'b00, 1, 1, 32'h5555_0000, 0);
        chk("t6_cont", o_addr, 32'h4);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(299) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(9) < 8,
                      $urandom_range(9) == 0,
                      $urandom & 32'hFFFF_FFFE,
                      ($urandom_range(3) == 0) ? 2'($urandom_range(3)) : 2'b00,
                      $urandom_range(9) < 6,
                      $urandom_range(1) == 1,
                      $urandom,
                      $urandom_range(7) == 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
